// File: rtl/axis_prog_loader.sv
// axis_prog_loader: assembles narrow AXI-Stream beats into instruction words
// and writes them to instruction memory at consecutive addresses from 0.
// Reports program length, completion, and malformed/oversized packets.
module axis_prog_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int S_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [S_WIDTH-1:0]    s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   prog_len
);

  localparam int BEATS  = DATA_WIDTH / S_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0]   LAST_K = BEAT_W'(BEATS - 1);
  // Program length at full capacity (2**ADDR_WIDTH); needs the extra bit.
  localparam logic [ADDR_WIDTH:0] CAP    = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [DATA_WIDTH-1:0]   asm_q, asm_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     prog_len_q, prog_len_d;
  logic                    error_q, error_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    done_q, done_d;

  logic accept;
  logic word_done;
  logic full;

  assign accept    = s_tvalid & s_tready;
  assign word_done = accept & (beat_q == LAST_K);
  assign full      = (prog_len_q == CAP);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (load_start) state_d = LOAD;
      LOAD: begin
        if (accept && s_tlast)    state_d = IDLE;
        else if (word_done && full) state_d = DRAIN;
      end
      DRAIN: if (accept && s_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    s_tready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      LOAD, DRAIN: begin
        s_tready = 1'b1;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: beat assembly, write issue, length and error tracking.
  always_comb begin
    beat_d     = beat_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    prog_len_d = prog_len_q;
    error_d    = error_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          beat_d     = '0;
          asm_d      = '0;
          addr_d     = '0;
          prog_len_d = '0;
          error_d    = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          // First beat lands in the least-significant slice.
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == BEAT_W'(k)) asm_d[k*S_WIDTH +: S_WIDTH] = s_tdata;
          end
          if (beat_q == LAST_K) begin
            beat_d = '0;
            if (full) begin
              // Memory already full: drop the word rather than overwrite.
              error_d = 1'b1;
            end else begin
              wr_en_d    = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = asm_d;
              addr_d     = addr_q + ADDR_WIDTH'(1);
              prog_len_d = prog_len_q + (ADDR_WIDTH+1)'(1);
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
          if (s_tlast) begin
            done_d = 1'b1;
            beat_d = '0;
            // Packet ended mid-word: the partial word is discarded.
            if (beat_q != LAST_K) error_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && s_tlast) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: the assembly register is reset too; it is one word, not a memory,
    // so the cost is trivial and reset state is fully defined.
    if (rst) begin
      beat_q     <= '0;
      asm_q      <= '0;
      addr_q     <= '0;
      prog_len_q <= '0;
      error_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      prog_len_q <= prog_len_d;
      error_q    <= error_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = done_q;
  assign error    = error_q;
  assign prog_len = prog_len_q;

endmodule

// File: tb/tb_axis_prog_loader.sv
// Testbench for axis_prog_loader: directed and randomized packets checked
// against a packet-level reference model of the expected memory writes.
module tb_axis_prog_loader;

  localparam int AW    = 2;
  localparam int DW    = 64;
  localparam int SW    = 32;
  localparam int BEATS = DW / SW;
  localparam int CAP   = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [SW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   prog_len;

  axis_prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .S_WIDTH(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .prog_len   (prog_len)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every write with the cycle it appeared in.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            t;
  } wr_t;

  wr_t  wq[$];
  int   cyc = 0;
  int   done_cnt = 0;
  logic wr_at_done = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back(wr_t'{a: wr_addr, d: wr_data, t: cyc});
    if (done === 1'b1) begin
      done_cnt++;
      wr_at_done = wr_en;
    end
  end

  logic [SW-1:0] pkt[$];
  int            restart_at = -1;

  // Drives one load: load_start pulse then the packet in pkt.
  // stall_pct < 0 selects the fixed valid pattern 1,0,0,1,0,0,...
  task automatic run_load(input int stall_pct, input string tag);
    int idx = 0;
    int cycles = 0;
    bit to = 0;
    bit v;
    bit restarted = 0;
    wq.delete();
    done_cnt = 0;
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    check({tag, "_ready_lat"}, s_tready, 1);
    check({tag, "_busy"}, busy, 1);
    while (idx < pkt.size()) begin
      if (cycles > 500) begin
        to = 1;
        break;
      end
      if (stall_pct < 0) v = (cycles % 3 == 0);
      else               v = (int'($urandom_range(0, 99)) >= stall_pct);
      s_tvalid   = v;
      s_tdata    = v ? pkt[idx] : $urandom;
      s_tlast    = v && (idx == pkt.size() - 1);
      load_start = (idx == restart_at) && !restarted;
      if (load_start) restarted = 1;
      if (v && s_tready) idx++;
      @(negedge clk);
      cycles++;
    end
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    load_start = 1'b0;
    check({tag, "_timeout"}, to, 0);
    check({tag, "_done_lat"}, done, 1);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_ready_fall"}, s_tready, 0);
    repeat (3) @(negedge clk);
  endtask

  // Reference: from the packet alone, the words that fit in memory are written
  // in order; malformed (partial) or oversized packets flag an error.
  task automatic verify(input string tag, input bit no_stall);
    int nfull = pkt.size() / BEATS;
    int nexp  = (nfull > CAP) ? CAP : nfull;
    bit err   = (pkt.size() % BEATS != 0) || (nfull > CAP);
    bit last_wr = (pkt.size() % BEATS == 0) && (nfull <= CAP);
    logic [DW-1:0] word;
    int n;
    check({tag, "_nwrites"}, wq.size(), nexp);
    n = (wq.size() < nexp) ? wq.size() : nexp;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < BEATS; b++) word[b*SW +: SW] = pkt[i*BEATS + b];
      check($sformatf("%s_addr%0d", tag, i), wq[i].a, i % CAP);
      check($sformatf("%s_data%0d", tag, i), wq[i].d, word);
      if (no_stall && i > 0)
        check($sformatf("%s_rate%0d", tag, i), wq[i].t - wq[i-1].t, BEATS);
    end
    check({tag, "_prog_len"}, prog_len, nexp);
    check({tag, "_error"}, error, err);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_wr_at_done"}, wr_at_done, last_wr);
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    s_tdata    = '0;
    repeat (3) @(negedge clk);
    check("rst_tready", s_tready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_prog_len", prog_len, 0);
    rst = 1'b0;
    @(negedge clk);

    // Normal load.
    pkt = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run_load(0, "normal");
    verify("normal", 1);

    // Same data with valid toggling 1,0,0.
    run_load(-1, "stall");
    verify("stall", 0);

    // Partial final instruction.
    pkt = '{32'hA0000001, 32'hA0000002, 32'hA0000003};
    run_load(0, "partial");
    verify("partial", 1);

    // Overflow: five instructions into four slots, TLAST on the fifth.
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(32'hB0000000 + i);
    run_load(0, "ovf");
    verify("ovf", 1);

    // Overflow followed by a drained tail.
    pkt.delete();
    for (int i = 0; i < 13; i++) pkt.push_back(32'hC0000000 + i);
    run_load(0, "drain");
    verify("drain", 1);

    // Clean load after errors: error and prog_len restart from zero.
    pkt = '{32'hD1, 32'hD2};
    run_load(0, "clean");
    verify("clean", 1);

    // Ignored restart in the middle of a load.
    pkt = '{32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hE5, 32'hE6};
    restart_at = 3;
    run_load(0, "restart");
    restart_at = -1;
    verify("restart", 1);

    // Reset mid-load.
    wq.delete();
    @(negedge clk) load_start = 1'b1;
    @(negedge clk) load_start = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'hF00DF00D;
    @(negedge clk) s_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("mrst_tready", s_tready, 0);
    check("mrst_wr_en", wr_en, 0);
    check("mrst_wr_addr", wr_addr, 0);
    check("mrst_wr_data", wr_data, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_error", error, 0);
    check("mrst_prog_len", prog_len, 0);
    repeat (2) @(negedge clk);
    check("mrst_no_write", wq.size(), 0);
    pkt = '{32'h12345678, 32'h9ABCDEF0};
    run_load(0, "after_rst");
    verify("after_rst", 1);

    // Randomized packets with random stalls.
    for (int r = 0; r < 25; r++) begin
      int len = $urandom_range(1, 13);
      int st  = $urandom_range(0, 60);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back($urandom);
      run_load(st, $sformatf("rnd%0d", r));
      verify($sformatf("rnd%0d", r), st == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
